seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial bit-sequence detector for the sequence-detect block family. It compares a qualified serial input stream against a compile-time pattern of 1 to 16 bits. It supports overlapping (repeat) or non-overlapping detection and issues a registered one-cycle match pulse. An optional saturating match counter feeds status logic. It sits between a serial front end (deserialiser or bit slicer) and control/status registers.

## Interface
- PAT_LEN, 5, pattern length in bits; legal range 1..16.
- PATTERN, 16'h0012, pattern value. Bits [PAT_LEN-1:0] are used and the upper bits are ignored. Bit PAT_LEN-1 is the first bit received. The default gives 10010 for PAT_LEN=5.
- REPEAT, 1, 1 = overlapping detection; 0 = non-overlapping detection.
- CNT_W, 8, width of the match counter.
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- din  input  1  serial data bit.
- din_vld  input  1  din is sampled only when high.
- clr  input  1  synchronous clear of detector and counter.
- match  output  1  one-cycle registered match pulse.
- match_cnt  output  CNT_W  saturating match count. Present only with SEQ_DET_CNT_EN.

## Operation
- State:
  - hist[PAT_LEN-1:0] holds the most recent accepted bits; the newest bit is in the LSB.
  - fill (0..PAT_LEN) counts valid history bits.
- Accepted bit (din_vld=1, clr=0):
  - hist_n = {hist[PAT_LEN-2:0], din}. For PAT_LEN=1, hist_n = din.
  - fill_n = min(fill+1, PAT_LEN).
- hit = (fill_n == PAT_LEN) && (hist_n == PATTERN[PAT_LEN-1:0]).
- On hit:
  - REPEAT=1: hist and fill update normally, so the pattern suffix may start the next match.
  - REPEAT=0: fill is cleared to 0 and the history is discarded. The next match needs PAT_LEN fresh bits.
- match is registered: match <= hit when a bit is accepted, otherwise 0. It is never high for two cycles from one hit.
- din_vld=0: hist, fill and the counter hold; match <= 0. Gaps of any length do not break a partial sequence.
- clr=1: hist, fill and match are set to 0 on the next edge, and the counter is cleared. clr has priority over din_vld in the same cycle, and the bit presented that cycle is dropped.
- Bits are compared only once fill reaches PAT_LEN, so all-zero history after reset or clear can never produce a false match on 0-heavy patterns.

## Timing
- Reset values: match=0, match_cnt=0, hist=0, fill=0.
- Latency: match is high during the cycle immediately after the rising edge that accepts the final pattern bit, which is 1 clock after the bit is presented.
- Back-to-back: with REPEAT=1 and a pattern that overlaps with itself, match can pulse on consecutive accepted bits, e.g. PATTERN=11 with input 111 gives pulses after bits 2 and 3.
- Reset mid-sequence: asserting rst_n low discards the partial sequence immediately. After release, a full PAT_LEN bits are needed.
- Counter: increments on the same edge that sets match, so it is visible in the same cycle as the pulse. It saturates at 2^CNT_W-1, and hits after saturation do not change it. clr on the same edge as a hit gives count 0, with no increment.

## Configuration
- SEQ_DET_CNT_EN:
  - Defined: the match_cnt port and the CNT_W-bit saturating counter are built.
  - Undefined: the match_cnt port and its logic are absent. CNT_W is ignored, and match behaviour is identical.

## Test plan
- Defaults (10010, REPEAT=1), din stream 1,0,0,1,0,0,1,0 with din_vld=1 → match pulses after bits 5 and 8; match_cnt=2.
- Same stream with REPEAT=0 → single pulse after bit 5, none after bit 8; match_cnt=1.
- Stream 1,0,0,1,0 with din_vld=0 for 3 cycles between bits 2 and 3 → one pulse after bit 5; match stays 0 during the gap.
- clr after bits 1,0,0, then 1,0,0,1,0 → exactly one pulse, after the final 0; match_cnt=1. Also clr on the hit edge → no pulse, count 0.
- rst_n low after bits 1,0,0,1 for 2 cycles, then 0,1,0,0,1,0 → first 0 yields no match; one pulse after the final 0.
- CNT_W=2, ten non-overlapping matches → match_cnt stops at 3. PAT_LEN=1 with PATTERN=1 and input 1,1,0,1 → pulses after bits 1, 2 and 4.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial bit-sequence detector with overlapping/non-overlapping modes.
// Define SEQ_DET_CNT_EN to build the match_cnt port and saturating counter.
module seq_detect_param #(
  parameter int          PAT_LEN = 5,
  parameter logic [15:0] PATTERN = 16'h0012,
  parameter int          REPEAT  = 1,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             match
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  localparam logic [PAT_LEN-1:0] PAT = PATTERN[PAT_LEN-1:0];

  if (PAT_LEN < 1 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: illegal PAT_LEN or CNT_W");
  end

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_n;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_n;
  logic               hit;
  logic               take;

  if (PAT_LEN == 1) begin : g_one
    assign hist_n = din;
  end else begin : g_shift
    assign hist_n = {hist[PAT_LEN-2:0], din};
  end

  assign take   = din_vld && !clr;
  assign fill_n = (fill == FULL) ? fill : fill + FW'(1);
  // Comparing only on a full history keeps reset zeros out of the match.
  assign hit    = (fill_n == FULL) && (hist_n == PAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (clr) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (din_vld) begin
      match <= hit;
      if (hit && REPEAT == 0) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_n;
        fill <= fill_n;
      end
    end else begin
      match <= 1'b0;
    end
  end

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (clr) begin
      match_cnt <= '0;
    end else if (take && hit && match_cnt != '1) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
